// File: rtl/fpu_pkg.sv
// Shared types for the FP operand issue path: FSM encoding, single-precision field
// positions and the operand bundle carried from the datapath to the add/sub unit.
package fpu_pkg;

  localparam int unsigned FP_N     = 32;
  localparam int unsigned SIGN_BIT = 31;
  localparam int unsigned EXP_MSB  = 30;
  localparam int unsigned EXP_LSB  = 23;
  localparam int unsigned FRAC_MSB = 22;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_t;

  typedef struct packed {
    logic [FP_N-1:0] a;
    logic [FP_N-1:0] b;
    logic            mode;
  } operand_t;

endpackage

// File: rtl/fpu_operand_fifo.sv
// DEPTH-entry register FIFO for operand bundles; flush clears pointers and count and
// wins over a simultaneous push or pop.
module fpu_operand_fifo #(
  parameter int unsigned W     = 65,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [W-1:0]                 wr_data,
  output logic [W-1:0]                 rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/fp_operand_issue.sv
// Operand queue and issue sequencer in front of the FP add/sub unit: one start pulse per
// queued pair, next issue only after op_done. Optional watchdog: FPU_ISSUE_WATCHDOG_EN.
module fp_operand_issue
  import fpu_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TMO   = 64
) (
  input  logic                        Clock,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N-1:0]                in_a,
  input  logic [N-1:0]                in_b,
  input  logic                        in_mode,
  input  logic                        flush,
  input  logic                        op_done,
  output logic                        start,
  output logic [N-1:0]                A,
  output logic [N-1:0]                B,
  output logic                        mode,
  output logic                        busy,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  output logic                        wd_err
);

  localparam int unsigned BW = 2 * N + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TMO < 2)) begin : g_bad_params
    $error("fp_operand_issue: DEPTH must be a power of two >= 2 and TMO >= 2");
  end

  state_t        state;
  state_t        state_nx;
  logic          pop;
  logic          start_nx;
  logic          busy_nx;
  logic          wd_hit_c;
  logic          full;
  logic          empty;
  logic [BW-1:0] head;

  fpu_operand_fifo #(
    .W     (BW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (Clock),
    .rst_n   (reset),
    .push    (in_valid),
    .pop     (pop),
    .flush   (flush),
    .wr_data ({in_a, in_b, in_mode}),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  assign in_ready = !full;

  // Next-state and registered-output next values.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !flush) begin
          pop      = 1'b1;
          state_nx = LAUNCH;
        end
      end
      LAUNCH: state_nx = WAIT;
      WAIT: begin
        if (op_done || wd_hit_c) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    start_nx = (state_nx == LAUNCH);
    busy_nx  = (state_nx != IDLE);
  end

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      start <= 1'b0;
      busy  <= 1'b0;
      A     <= '0;
      B     <= '0;
      mode  <= 1'b0;
    end else begin
      state <= state_nx;
      start <= start_nx;
      busy  <= busy_nx;
      if (pop) {A, B, mode} <= head;
    end
  end

`ifdef FPU_ISSUE_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TMO);

  logic [WD_W-1:0] wd_cnt;

  // wd_cnt holds cycles elapsed since the start pulse; hitting TMO-1 in WAIT aborts the op.
  assign wd_hit_c = (state == WAIT) && !op_done && (wd_cnt == WD_W'(TMO - 1));

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      wd_cnt <= '0;
      wd_err <= 1'b0;
    end else begin
      if (state == LAUNCH)                wd_cnt <= WD_W'(1);
      else if (state == WAIT && !wd_hit_c) wd_cnt <= wd_cnt + WD_W'(1);
      if (wd_hit_c) wd_err <= 1'b1;
    end
  end
`else
  assign wd_hit_c = 1'b0;
  assign wd_err   = 1'b0;
`endif

endmodule

// File: tb/tb_fp_operand_issue.sv
// Directed bench for fp_operand_issue: vector table for the basic issue/latency behaviour,
// hand sequences for full queue, flush, reset-in-flight and (if enabled) the watchdog.
module tb_fp_operand_issue;

  localparam int unsigned N     = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          Clock;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_a;
  logic [N-1:0]  in_b;
  logic          in_mode;
  logic          flush;
  logic          op_done;
  logic          start;
  logic [N-1:0]  A;
  logic [N-1:0]  B;
  logic          mode;
  logic          busy;
  logic [CW-1:0] count;
  logic          wd_err;

  int n_cmp;
  int n_err;

  fp_operand_issue #(.N(N), .DEPTH(DEPTH), .TMO(64)) dut (
    .Clock    (Clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_mode  (in_mode),
    .flush    (flush),
    .op_done  (op_done),
    .start    (start),
    .A        (A),
    .B        (B),
    .mode     (mode),
    .busy     (busy),
    .count    (count),
    .wd_err   (wd_err)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic          v;
    logic [31:0]   a;
    logic [31:0]   b;
    logic          m;
    logic          fl;
    logic          od;
    logic          e_start;
    logic          e_busy;
    logic          e_ready;
    logic [CW-1:0] e_count;
    logic [31:0]   e_A;
    logic [31:0]   e_B;
    logic          e_mode;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic push_pair(input logic [31:0] a, input logic [31:0] b, input logic m);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_mode  = m;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_ready) done = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    if (!done) chk("push_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic complete_op();
    op_done = 1'b1;
    tick();
    op_done = 1'b0;
    chk("busy_after_done", 32'(busy), 32'd0);
  endtask

  task automatic issue_next(input logic [31:0] ea, input logic [31:0] eb);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (start) seen = 1'b1;
    end
    chk("issue_start_seen", 32'(seen), 32'd1);
    chk("issue_A", A, ea);
    chk("issue_B", B, eb);
    tick();
    chk("issue_busy_wait", 32'(busy), 32'd1);
    complete_op();
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] pa [6];
    logic [31:0] pb [6];
    int          starts;

    n_cmp    = 0;
    n_err    = 0;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_mode  = 1'b0;
    flush    = 1'b0;
    op_done  = 1'b0;

    //           v  a             b             m  fl od  st bz rd cnt  A             B             md
    tbl[0]  = '{1, 32'h3F800000, 32'h40000000, 0, 0, 0,  0, 0, 1, 3'd1, 32'h0,        32'h0,        0};
    tbl[1]  = '{0, 32'h0,        32'h0,        0, 0, 0,  1, 1, 1, 3'd0, 32'h3F800000, 32'h40000000, 0};
    tbl[2]  = '{0, 32'h0,        32'h0,        0, 0, 0,  0, 1, 1, 3'd0, 32'h3F800000, 32'h40000000, 0};
    tbl[3]  = '{0, 32'h0,        32'h0,        0, 0, 0,  0, 1, 1, 3'd0, 32'h3F800000, 32'h40000000, 0};
    tbl[4]  = '{0, 32'h0,        32'h0,        0, 0, 1,  0, 0, 1, 3'd0, 32'h3F800000, 32'h40000000, 0};
    tbl[5]  = '{0, 32'h0,        32'h0,        0, 0, 1,  0, 0, 1, 3'd0, 32'h3F800000, 32'h40000000, 0};
    tbl[6]  = '{1, 32'h40400000, 32'h3F000000, 1, 0, 0,  0, 0, 1, 3'd1, 32'h3F800000, 32'h40000000, 0};
    tbl[7]  = '{1, 32'hC0000000, 32'h40800000, 0, 0, 0,  1, 1, 1, 3'd1, 32'h40400000, 32'h3F000000, 1};
    tbl[8]  = '{0, 32'h0,        32'h0,        0, 0, 0,  0, 1, 1, 3'd1, 32'h40400000, 32'h3F000000, 1};
    tbl[9]  = '{0, 32'h0,        32'h0,        0, 0, 1,  0, 0, 1, 3'd1, 32'h40400000, 32'h3F000000, 1};
    tbl[10] = '{0, 32'h0,        32'h0,        0, 0, 0,  1, 1, 1, 3'd0, 32'hC0000000, 32'h40800000, 0};
    tbl[11] = '{0, 32'h0,        32'h0,        0, 0, 1,  0, 1, 1, 3'd0, 32'hC0000000, 32'h40800000, 0};
    tbl[12] = '{0, 32'h0,        32'h0,        0, 0, 1,  0, 0, 1, 3'd0, 32'hC0000000, 32'h40800000, 0};

    // Reset values
    tick();
    tick();
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_A", A, 32'd0);
    chk("rst_B", B, 32'd0);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_wd_err", 32'(wd_err), 32'd0);
    reset = 1'b1;
    tick();

    // Table: single issue, latency, op_done outside WAIT, push+pop same cycle
    for (int i = 0; i < 13; i++) begin
      in_valid = tbl[i].v;
      in_a     = tbl[i].a;
      in_b     = tbl[i].b;
      in_mode  = tbl[i].m;
      flush    = tbl[i].fl;
      op_done  = tbl[i].od;
      tick();
      chk($sformatf("vec%0d_start", i), 32'(start), 32'(tbl[i].e_start));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("vec%0d_ready", i), 32'(in_ready), 32'(tbl[i].e_ready));
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].e_count));
      chk($sformatf("vec%0d_A", i), A, tbl[i].e_A);
      chk($sformatf("vec%0d_B", i), B, tbl[i].e_B);
      chk($sformatf("vec%0d_mode", i), 32'(mode), 32'(tbl[i].e_mode));
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    op_done  = 1'b0;

    // Fill queue behind an in-flight op; sixth pair held off while full
    for (int k = 0; k < 6; k++) begin
      pa[k] = 32'h41000000 + 32'(k);
      pb[k] = 32'h42100000 + 32'(k);
    end
    for (int k = 0; k < 5; k++) push_pair(pa[k], pb[k], 1'b0);
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(in_ready), 32'd0);
    chk("full_inflight_A", A, pa[0]);
    chk("full_busy", 32'(busy), 32'd1);
    in_valid = 1'b1;
    in_a     = pa[5];
    in_b     = pb[5];
    for (int i = 0; i < 3; i++) tick();
    chk("held_count", 32'(count), 32'd4);
    chk("held_ready", 32'(in_ready), 32'd0);
    complete_op();
    chk("done_count", 32'(count), 32'd4);
    tick();
    chk("pop_start", 32'(start), 32'd1);
    chk("pop_A", A, pa[1]);
    chk("pop_count", 32'(count), 32'd3);
    chk("pop_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("refill_count", 32'(count), 32'd4);
    chk("refill_A_stable", A, pa[1]);
    complete_op();
    for (int k = 2; k < 6; k++) issue_next(pa[k], pb[k]);
    starts = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (start) starts++;
    end
    chk("drain_no_extra_start", 32'(starts), 32'd0);
    chk("drain_count", 32'(count), 32'd0);

    // Flush with 3 queued and one in flight; flush beats a simultaneous push
    for (int k = 0; k < 4; k++) push_pair(32'h43000000 + 32'(k), 32'h44000000 + 32'(k), 1'b1);
    chk("preflush_count", 32'(count), 32'd3);
    in_valid = 1'b1;
    in_a     = 32'hDEADBEEF;
    in_b     = 32'h0BADF00D;
    flush    = 1'b1;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_A", A, 32'h43000000);
    chk("flush_B", B, 32'h44000000);
    chk("flush_busy", 32'(busy), 32'd1);
    complete_op();
    starts = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (start) starts++;
    end
    chk("flush_no_start", 32'(starts), 32'd0);

    // Reset in WAIT with one more queued
    push_pair(32'h45000000, 32'h46000000, 1'b0);
    push_pair(32'h45000001, 32'h46000001, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_start", 32'(start), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_A", A, 32'd0);
    #2;
    reset = 1'b1;
    starts = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (start || busy) starts++;
    end
    chk("post_rst_idle", 32'(starts), 32'd0);
    push_pair(32'h47000000, 32'h48000000, 1'b1);
    chk("post_rst_lat1", 32'(start), 32'd0);
    tick();
    chk("post_rst_start", 32'(start), 32'd1);
    chk("post_rst_A", A, 32'h47000000);
    chk("post_rst_mode", 32'(mode), 32'd1);
    tick();
    complete_op();

`ifdef FPU_ISSUE_WATCHDOG_EN
    // Withheld op_done: abort exactly 64 cycles after start, then next pair issues
    push_pair(32'h49000000, 32'h4A000000, 1'b0);
    push_pair(32'h49000001, 32'h4A000001, 1'b0);
    chk("wd_start", 32'(start), 32'd1);
    chk("wd_A", A, 32'h49000000);
    for (int i = 0; i < 63; i++) tick();
    chk("wd_busy_63", 32'(busy), 32'd1);
    chk("wd_err_63", 32'(wd_err), 32'd0);
    tick();
    chk("wd_busy_64", 32'(busy), 32'd0);
    chk("wd_err_64", 32'(wd_err), 32'd1);
    issue_next(32'h49000001, 32'h4A000001);
    chk("wd_err_sticky", 32'(wd_err), 32'd1);
`else
    chk("wd_err_tied", 32'(wd_err), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
